// File: rtl/ved_mult_iter.sv
// Iterative WIDTH x WIDTH multiplier built around a single (WIDTH/2)x(WIDTH/2) Vedic core,
// stepping through the four Urdhva partial products with valid/ready on both sides.
module ved_mult_iter #(
    parameter int WIDTH     = 64,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 busy
);

    localparam int H  = WIDTH / 2;
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(H + 1);

    typedef enum logic [2:0] {IDLE, MUL0, MUL1, MUL2, MUL3, FIX, DONE} state_t;

    state_t            state, state_next;
    logic [WIDTH-1:0]  ra, rb, a_mag, b_mag;
    logic              neg, take_signed;
    logic [PW-1:0]     acc, prod_ext;
    logic [H-1:0]      core_x, core_y;
    logic [WIDTH-1:0]  core_p;
    logic [CW-1:0]     colsum [0:2*H-2];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_next = MUL0;
            end
            MUL0: state_next = MUL1;
            MUL1: state_next = MUL2;
            MUL2: state_next = MUL3;
            MUL3: state_next = FIX;
            FIX:  state_next = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Signed operands are reduced to magnitudes; -2^(W-1) maps onto itself, read as unsigned.
    always_comb begin
        take_signed = SIGNED_EN && is_signed;
        a_mag = (take_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
        b_mag = (take_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
    end

    always_comb begin
        core_x = ra[H-1:0];
        core_y = rb[H-1:0];
        case (state)
            MUL1: core_x = ra[WIDTH-1:H];
            MUL2: core_y = rb[WIDTH-1:H];
            MUL3: begin
                core_x = ra[WIDTH-1:H];
                core_y = rb[WIDTH-1:H];
            end
            default: ;
        endcase
    end

    // Urdhva-tiryakbhyam: vertical/crosswise column sums first, then one carry-resolving sum.
    always_comb begin
        for (int k = 0; k < 2*H-1; k++) colsum[k] = '0;
        for (int i = 0; i < H; i++) begin
            for (int j = 0; j < H; j++) begin
                colsum[i+j] = colsum[i+j] + CW'(core_x[i] & core_y[j]);
            end
        end
        core_p = '0;
        for (int k = 0; k < 2*H-1; k++) begin
            core_p = core_p + (WIDTH'(colsum[k]) << k);
        end
    end

    assign prod_ext = {{WIDTH{1'b0}}, core_p};

    always_ff @(posedge clk) begin
        if (rst) begin
            ra     <= '0;
            rb     <= '0;
            neg    <= 1'b0;
            acc    <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        ra  <= a_mag;
                        rb  <= b_mag;
                        neg <= take_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                    end
                end
                MUL0:       acc <= prod_ext;
                MUL1, MUL2: acc <= acc + (prod_ext << H);
                MUL3:       acc <= acc + {core_p, {WIDTH{1'b0}}};
                FIX:        result <= neg ? (~acc + PW'(1)) : acc;
                default: ;
            endcase
        end
    end

endmodule
